cpu_mem_bridge: RTL

Downstream of the multicycle RV32I control/datapath memory port. Converts single-word CPU requests (`mem_read`/`mem_write`/`mem_byte_enable`, held until `mem_resp`) into 4-beat, 64-bit burst transactions on the physical-memory port, one 256-bit line per burst. A single-entry line buffer serves repeat reads to the same line without a burst. Writes are merged into the line and written through.

---
 rtl/cpu_mem_bridge_pkg.sv | 44 ++++
 rtl/bridge_line_buf.sv | 62 ++++++
 rtl/cpu_mem_bridge.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_bridge_pkg.sv
// Shared types for the CPU-to-physical-memory bridge.
// Provides line/beat/tag widths, the bridge FSM state enum, the captured
// CPU request payload, and the byte-lane word merge helper.
package mem_bridge_types;

  localparam int unsigned LINE_BITS = 256;
  localparam int unsigned BEAT_BITS = 64;
  localparam int unsigned BEATS     = 4;
  localparam int unsigned WORD_BITS = 32;
  localparam int unsigned TAG_BITS  = 27;

  typedef logic [LINE_BITS-1:0] line_t;
  typedef logic [BEAT_BITS-1:0] beat_t;
  typedef logic [TAG_BITS-1:0]  tag_t;
  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WB    = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // CPU request captured in IDLE and held for the whole transaction
  typedef struct packed {
    logic       is_wr;
    tag_t       line;
    logic [2:0] word;
    word_t      wdata;
    logic [3:0] be;
  } req_t;

  // Replace the byte lanes selected by be with bytes from new_w
  function automatic word_t merge_word(word_t old_w, word_t new_w, logic [3:0] be);
    word_t r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/bridge_line_buf.sv
// Single-entry line buffer: valid bit, line tag and 256-bit line data.
// Ports: clear_i (drop valid), beat_we_i/beat_idx_i/beat_i (fill one beat),
// fill_done_i/tag_i (mark line valid with tag), merge_we_i/merge_idx_i/
// merge_wdata_i/merge_be_i (byte-enable word merge), rd_word_idx_i/rd_word_o
// and rd_beat_idx_i/rd_beat_o (read muxes), valid_o/tag_o (hit compare).
module bridge_line_buf
  import mem_bridge_types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       beat_we_i,
  input  logic [1:0] beat_idx_i,
  input  beat_t      beat_i,
  input  logic       fill_done_i,
  input  tag_t       tag_i,
  input  logic       merge_we_i,
  input  logic [2:0] merge_idx_i,
  input  word_t      merge_wdata_i,
  input  logic [3:0] merge_be_i,
  input  logic [2:0] rd_word_idx_i,
  output word_t      rd_word_o,
  input  logic [1:0] rd_beat_idx_i,
  output beat_t      rd_beat_o,
  output logic       valid_o,
  output tag_t       tag_o
);

  logic  valid_q;
  tag_t  tag_q;
  line_t data_q;
  word_t merge_old;

  assign merge_old = data_q[32'(merge_idx_i)*WORD_BITS +: WORD_BITS];

  // Storage update: beat fill and word merge never coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      if (beat_we_i) data_q[32'(beat_idx_i)*BEAT_BITS +: BEAT_BITS] <= beat_i;
      if (merge_we_i) begin
        data_q[32'(merge_idx_i)*WORD_BITS +: WORD_BITS] <=
          merge_word(merge_old, merge_wdata_i, merge_be_i);
      end
      if (clear_i) begin
        valid_q <= 1'b0;
      end else if (fill_done_i) begin
        valid_q <= 1'b1;
        tag_q   <= tag_i;
      end
    end
  end

  assign rd_word_o = data_q[32'(rd_word_idx_i)*WORD_BITS +: WORD_BITS];
  assign rd_beat_o = data_q[32'(rd_beat_idx_i)*BEAT_BITS +: BEAT_BITS];
  assign valid_o   = valid_q;
  assign tag_o     = tag_q;

endmodule

// File: rtl/cpu_mem_bridge.sv
// Bridge from single-word CPU requests to 4-beat 64-bit line bursts.
// CPU side: mem_read/mem_write/mem_byte_enable/mem_address/mem_wdata in,
// mem_rdata/mem_resp out. Memory side: pmem_read/pmem_write/pmem_address/
// pmem_wdata out, pmem_rdata/pmem_resp in. Sync active-high rst.
// Macro CPU_MEM_BRIDGE_LINEBUF_EN keeps the line buffer valid between
// transactions so repeat accesses to the same line hit; without it every
// access refills.
module cpu_mem_bridge
  import mem_bridge_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [63:0] pmem_wdata,
  input  logic [63:0] pmem_rdata,
  input  logic        pmem_resp
);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  req_t       req_q, req_d;
  word_t      rdata_q, rdata_d;
  beat_t      wdata_q, wdata_d;
  logic       resp_q, rd_q, wr_q;

  logic       buf_valid, buf_clear, beat_we, fill_done, merge_we, hit;
  tag_t       buf_tag;
  word_t      buf_word;
  beat_t      buf_beat, wb_beat;
  logic [2:0] rd_word_idx;
  logic [1:0] rd_beat_idx;
  logic       addr_unused;

  assign addr_unused = ^mem_address[1:0];

  bridge_line_buf u_buf (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (buf_clear),
    .beat_we_i     (beat_we),
    .beat_idx_i    (cnt_q),
    .beat_i        (pmem_rdata),
    .fill_done_i   (fill_done),
    .tag_i         (req_q.line),
    .merge_we_i    (merge_we),
    .merge_idx_i   (req_q.word),
    .merge_wdata_i (req_q.wdata),
    .merge_be_i    (req_q.be),
    .rd_word_idx_i (rd_word_idx),
    .rd_word_o     (buf_word),
    .rd_beat_idx_i (rd_beat_idx),
    .rd_beat_o     (buf_beat),
    .valid_o       (buf_valid),
    .tag_o         (buf_tag)
  );

`ifdef CPU_MEM_BRIDGE_LINEBUF_EN
  assign buf_clear = 1'b0;
`else
  // Drop the line on the way back to IDLE so the next access misses
  assign buf_clear = (state_q == ST_RESP);
`endif

  assign hit = buf_valid && (buf_tag == mem_address[31:5]);

  // In IDLE the live address selects the hit word; afterwards the captured one
  assign rd_word_idx = (state_q == ST_IDLE) ? mem_address[4:2] : req_q.word;
  // Preload the next write beat: beat 0 from MERGE, beat cnt+1 during WB
  assign rd_beat_idx = (state_q == ST_MERGE) ? 2'd0 : cnt_q + 2'd1;

  // Next-state and buffer control
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    beat_we   = 1'b0;
    fill_done = 1'b0;
    merge_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 2'd0;
        if (mem_write || mem_read) begin
          req_d.is_wr = mem_write;
          req_d.line  = mem_address[31:5];
          req_d.word  = mem_address[4:2];
          req_d.wdata = mem_wdata;
          req_d.be    = mem_byte_enable;
          if (hit) state_d = mem_write ? ST_MERGE : ST_RESP;
          else     state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (pmem_resp) begin
          beat_we = 1'b1;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            fill_done = 1'b1;
            state_d   = req_q.is_wr ? ST_MERGE : ST_RESP;
          end
        end
      end
      ST_MERGE: begin
        merge_we = 1'b1;
        state_d  = ST_WB;
      end
      ST_WB: begin
        if (pmem_resp) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered data outputs
  always_comb begin
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    wb_beat = buf_beat;
    // Buffer merge lands at the MERGE->WB edge, so patch beat 0 here
    if (state_q == ST_MERGE && req_q.word[2:1] == 2'd0) begin
      if (req_q.word[0]) wb_beat[63:32] = merge_word(buf_word, req_q.wdata, req_q.be);
      else               wb_beat[31:0]  = merge_word(buf_word, req_q.wdata, req_q.be);
    end
    if (state_q == ST_MERGE) begin
      wdata_d = wb_beat;
    end else if (state_q == ST_WB && pmem_resp && cnt_q != 2'd3) begin
      wdata_d = wb_beat;
    end
    if (state_d == ST_RESP) begin
      // Last fill beat is still on pmem_rdata, not yet in the buffer
      if (state_q == ST_FILL && req_q.word[2:1] == 2'd3) begin
        rdata_d = req_q.word[0] ? pmem_rdata[63:32] : pmem_rdata[31:0];
      end else begin
        rdata_d = buf_word;
      end
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      req_q   <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      resp_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      resp_q  <= (state_d == ST_RESP);
      rd_q    <= (state_d == ST_FILL);
      wr_q    <= (state_d == ST_WB);
    end
  end

  assign mem_rdata    = rdata_q;
  assign mem_resp     = resp_q;
  assign pmem_read    = rd_q;
  assign pmem_write   = wr_q;
  assign pmem_address = {req_q.line, 5'b0};
  assign pmem_wdata   = wdata_q;

endmodule
